frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the sample width.
REQ-002 SHALL have parameter FRAME_LEN, default 306, the samples per frame (range 2..1023).
REQ-003 SHALL have parameter SETTLE, default 2, the minimum cycles after wb_start_move_o before wb_valid_i is sampled (>=1).
REQ-004 Ports: clk  in  1  the single clock, rising edge.
REQ-005 Ports: rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports: enable_i  in  1  level; run frames continuously while high.
REQ-007 Ports: wb_start_move_o  out  1  one-cycle pulse requesting a window-buffer hop and refill.
REQ-008 Ports: wb_rd_en_o  out  1  pop one sample from the window buffer.
REQ-009 Ports: wb_data_i  in  WIDTH  window-buffer sample, valid in the same cycle as wb_valid_i.
REQ-010 Ports: wb_valid_i  in  1  window buffer has a readable sample.
REQ-011 Ports: m_data_o  out  WIDTH  sample to the downstream stage.
REQ-012 Ports: m_valid_o  out  1  m_data_o is valid.
REQ-013 Ports: m_ready_i  in  1  downstream accepts the sample.
REQ-014 Ports: m_index_o  out  10  position of m_data_o within the frame, 0..FRAME_LEN-1.
REQ-015 Ports: m_last_o  out  1  m_data_o is sample FRAME_LEN-1.
REQ-016 Ports: frame_count_o  out  16  completed frames, wrapping modulo 2^16.
REQ-017 Ports: busy_o  out  1  high in any state other than IDLE.

Function
REQ-018 States SHALL be IDLE, STREAM, MOVE_REQ and MOVE_WAIT.
REQ-019 IDLE->STREAM SHALL occur when enable_i=1; the sample counter clears to 0.
REQ-020 In STREAM, wb_rd_en_o SHALL be combinational: wb_valid_i & (~m_valid_o | m_ready_i) & (sample_cnt < FRAME_LEN).
REQ-021 In the wb_rd_en_o cycle, m_data_o SHALL take wb_data_i, m_index_o SHALL take sample_cnt, m_valid_o SHALL be set, and sample_cnt SHALL increment; latency is 1 cycle.
REQ-022 m_valid_o SHALL clear after a handshake (m_valid_o & m_ready_i) in which no new sample is loaded.
REQ-023 m_data_o, m_index_o and m_last_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-024 Back-to-back transfers SHALL sustain 1 sample/cycle when wb_valid_i=1 and m_ready_i=1.
REQ-025 m_last_o SHALL equal (m_index_o == FRAME_LEN-1) & m_valid_o.
REQ-026 STREAM->MOVE_REQ SHALL occur on the handshake of the m_last_o sample; frame_count_o SHALL increment in the same cycle.
REQ-027 MOVE_REQ SHALL assert wb_start_move_o for exactly one cycle.
REQ-028 From MOVE_REQ, if enable_i=1 the next state SHALL be MOVE_WAIT; otherwise it SHALL be IDLE, and no further hop is issued.
REQ-029 MOVE_WAIT SHALL count SETTLE cycles, ignoring wb_valid_i.
REQ-030 After the SETTLE count, MOVE_WAIT SHALL go to STREAM with sample_cnt=0 when wb_valid_i=1, and SHALL stay in MOVE_WAIT while wb_valid_i=0.
REQ-031 Dropping enable_i during STREAM SHALL NOT abort the frame; the full frame completes, then REQ-028 applies.
REQ-032 wb_rd_en_o SHALL be 0 outside STREAM, and SHALL be 0 once sample_cnt=FRAME_LEN until the next frame.
REQ-033 wb_start_move_o SHALL never be high in the same cycle as wb_rd_en_o.
REQ-034 frame_count_o SHALL wrap from 0xFFFF to 0x0000 without any side effect.

Reset
REQ-035 While rst_n=0, asynchronously: state=IDLE, sample_cnt=0, settle counter=0, and all outputs 0 (m_data_o, m_index_o, m_valid_o, m_last_o, wb_rd_en_o, wb_start_move_o, frame_count_o, busy_o).
REQ-036 Reset asserted mid-frame SHALL discard the in-flight sample with no handshake.
REQ-037 After reset release, the first frame SHALL start only via REQ-019; no hop is issued for the first frame.

Verification
REQ-038 enable_i=1, wb_valid_i=1, m_ready_i=1 -> 306 consecutive m_valid_o cycles, m_index_o 0..305, m_last_o only at 305, frame_count_o=1, then one wb_start_move_o pulse.
REQ-039 m_ready_i=0 for 5 cycles at index 100 -> m_data_o and m_index_o frozen at 100, wb_rd_en_o=0 for those cycles, no sample lost or duplicated.
REQ-040 After a hop, wb_valid_i held low for 10 cycles -> stays in MOVE_WAIT, wb_rd_en_o=0; streaming resumes at index 0 one cycle after wb_valid_i rises.
REQ-041 enable_i dropped at index 50 -> frame completes through 305, then one wb_start_move_o, then IDLE with busy_o=0.
REQ-042 rst_n pulsed low at index 200 -> all outputs 0 immediately; after release with enable_i=1, the next frame starts at index 0 with frame_count_o=0.
REQ-043 frame_count_o forced to 0xFFFF (or 65536 frames run) -> next completed frame yields 0x0000.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: pulls FRAME_LEN samples per frame from a window buffer,
// forwards them downstream over a valid/ready link with frame position and
// last flags, then requests a window hop and waits for the refill to settle.
module frame_sequencer #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 306,
    parameter int SETTLE    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    output logic             wb_start_move_o,
    output logic             wb_rd_en_o,
    input  logic [WIDTH-1:0] wb_data_i,
    input  logic             wb_valid_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [9:0]       m_index_o,
    output logic             m_last_o,
    output logic [15:0]      frame_count_o,
    output logic             busy_o
);

    // Settle counter width: must hold the value SETTLE itself.
    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    localparam logic [10:0]   LEN_V    = 11'(FRAME_LEN);
    localparam logic [9:0]    LAST_IDX = 10'(FRAME_LEN - 1);
    localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        MOVE_REQ  = 2'd2,
        MOVE_WAIT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [10:0]       sample_cnt_q, sample_cnt_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [WIDTH-1:0]  m_data_q, m_data_d;
    logic [9:0]        m_index_q, m_index_d;
    logic              m_valid_q, m_valid_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic              rd_en;
    logic              handshake;
    logic              last;

    // Pop a sample whenever the output register is free (or draining this
    // cycle) and the frame still has samples left to fetch.
    always_comb begin
        rd_en     = (state_q == STREAM) & wb_valid_i & (~m_valid_q | m_ready_i)
                    & (sample_cnt_q < LEN_V);
        handshake = m_valid_q & m_ready_i;
        last      = m_valid_q & (m_index_q == LAST_IDX);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d       = state_q;
        sample_cnt_d  = sample_cnt_q;
        settle_d      = settle_q;
        m_data_d      = m_data_q;
        m_index_d     = m_index_q;
        m_valid_d     = m_valid_q;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d      = STREAM;
                    sample_cnt_d = '0;
                end
            end

            STREAM: begin
                if (rd_en) begin
                    m_data_d     = wb_data_i;
                    m_index_d    = sample_cnt_q[9:0];
                    m_valid_d    = 1'b1;
                    sample_cnt_d = sample_cnt_q + 11'd1;
                end else if (handshake) begin
                    m_valid_d = 1'b0;
                end
                // Last sample accepted: the counter is exhausted, so no new
                // load can coincide with this handshake.
                if (handshake && last) begin
                    state_d       = MOVE_REQ;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end

            MOVE_REQ: begin
                settle_d = '0;
                state_d  = enable_i ? MOVE_WAIT : IDLE;
            end

            MOVE_WAIT: begin
                // wb_valid_i is not trusted until the refill has had SETTLE cycles.
                if (settle_q != SETTLE_V) begin
                    settle_d = settle_q + 1'b1;
                end else if (wb_valid_i) begin
                    state_d      = STREAM;
                    sample_cnt_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sample_cnt_q  <= '0;
            settle_q      <= '0;
            m_data_q      <= '0;
            m_index_q     <= '0;
            m_valid_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sample_cnt_q  <= sample_cnt_d;
            settle_q      <= settle_d;
            m_data_q      <= m_data_d;
            m_index_q     <= m_index_d;
            m_valid_q     <= m_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Output mapping; everything here decodes to 0 while in reset.
    always_comb begin
        wb_rd_en_o      = rd_en;
        wb_start_move_o = (state_q == MOVE_REQ);
        busy_o          = (state_q != IDLE);
        m_data_o        = m_data_q;
        m_index_o       = m_index_q;
        m_valid_o       = m_valid_q;
        m_last_o        = last;
        frame_count_o   = frame_count_q;
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a window-buffer source model and a
// handshake scoreboard checking sample order, index and last flag.
module tb_frame_sequencer;

    localparam int WIDTH = 16;
    localparam int FLEN  = 306;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable_i;
    logic             wb_start_move_o;
    logic             wb_rd_en_o;
    logic [WIDTH-1:0] wb_data_i;
    logic             wb_valid_i;
    logic [WIDTH-1:0] m_data_o;
    logic             m_valid_o;
    logic             m_ready_i;
    logic [9:0]       m_index_o;
    logic             m_last_o;
    logic [15:0]      frame_count_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    // window-buffer model: sequential samples, advanced on every pop
    logic [15:0] src = 16'd0;
    int          exp_src = 0;
    int          exp_idx = 0;

    assign wb_data_i = src ^ 16'h5A5A;

    frame_sequencer #(.WIDTH(WIDTH), .FRAME_LEN(FLEN), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
        .wb_start_move_o(wb_start_move_o), .wb_rd_en_o(wb_rd_en_o),
        .wb_data_i(wb_data_i), .wb_valid_i(wb_valid_i),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_index_o(m_index_o), .m_last_o(m_last_o),
        .frame_count_o(frame_count_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wb_rd_en_o) src <= src + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard on each accepted sample, plus hop/read exclusion
    always @(negedge clk) begin
        if (rst_n) begin
            chk("hop_vs_read", 32'(wb_start_move_o & wb_rd_en_o), 32'd0);
            if (m_valid_o && m_ready_i) begin
                chk("sb_data", 32'(m_data_o), 32'(16'(exp_src) ^ 16'h5A5A));
                chk("sb_index", 32'(m_index_o), 32'(exp_idx));
                chk("sb_last", 32'(m_last_o), 32'(exp_idx == FLEN - 1));
                exp_src = exp_src + 1;
                exp_idx = (exp_idx == FLEN - 1) ? 0 : exp_idx + 1;
            end
        end
    end

    // inputs change and outputs are read 2 time units after the rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idx(input int idx);
        for (int g = 0; g < 2000 && !(m_valid_o && m_index_o == 10'(idx)); g++) tick(1);
        chk("reach_index", 32'(m_valid_o && m_index_o == 10'(idx)), 32'd1);
    endtask

    task automatic wait_last();
        for (int g = 0; g < 2000 && !(m_valid_o && m_last_o && m_ready_i); g++) tick(1);
        chk("reach_last", 32'(m_valid_o && m_last_o), 32'd1);
    endtask

    initial begin
        int nv;
        int nl;
        int last_idx;
        logic [15:0] held;

        rst_n = 1'b0; enable_i = 1'b0; wb_valid_i = 1'b0; m_ready_i = 1'b0;
        tick(2);
        chk("rst_outputs", 32'({m_data_o, m_index_o, m_valid_o, m_last_o,
                                wb_rd_en_o, wb_start_move_o, busy_o}), 32'd0);
        chk("rst_fcount", 32'(frame_count_o), 32'd0);

        rst_n = 1'b1;
        tick(2);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_no_hop", 32'(wb_start_move_o), 32'd0);

        // frame 1: continuous flow
        enable_i = 1'b1; wb_valid_i = 1'b1; m_ready_i = 1'b1;
        tick(1);
        chk("start_busy", 32'(busy_o), 32'd1);
        chk("start_rd_en", 32'(wb_rd_en_o), 32'd1);
        chk("start_no_valid", 32'(m_valid_o), 32'd0);
        tick(1);
        nv = 0; nl = 0; last_idx = 0;
        while (m_valid_o && nv < 400) begin
            nv++;
            if (m_last_o) begin nl++; last_idx = int'(m_index_o); end
            tick(1);
        end
        chk("f1_valid_run", 32'(nv), 32'(FLEN));
        chk("f1_last_count", 32'(nl), 32'd1);
        chk("f1_last_index", 32'(last_idx), 32'(FLEN - 1));
        chk("f1_hop", 32'(wb_start_move_o), 32'd1);
        chk("f1_fcount", 32'(frame_count_o), 32'd1);

        // refill slow: buffer not ready for 10 cycles
        wb_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("wait_no_rd", 32'({wb_rd_en_o, wb_start_move_o, m_valid_o, busy_o}), 32'b0001);
        end
        wb_valid_i = 1'b1;
        tick(1);
        chk("resume_rd", 32'({wb_rd_en_o, m_valid_o}), 32'b10);
        tick(1);
        chk("resume_valid", 32'(m_valid_o), 32'd1);
        chk("resume_idx0", 32'(m_index_o), 32'd0);

        // frame 2: downstream stall at index 100
        wait_idx(100);
        m_ready_i = 1'b0;
        held = m_data_o;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall_idx", 32'(m_index_o), 32'd100);
            chk("stall_data", 32'(m_data_o), 32'(held));
            chk("stall_ctl", 32'({m_valid_o, wb_rd_en_o}), 32'b10);
        end
        m_ready_i = 1'b1;
        wait_last();
        tick(1);
        chk("f2_hop", 32'(wb_start_move_o), 32'd1);
        chk("f2_fcount", 32'(frame_count_o), 32'd2);

        // frame 3: enable dropped mid-frame
        wait_idx(0);
        wait_idx(50);
        enable_i = 1'b0;
        wait_last();
        chk("f3_completed_idx", 32'(m_index_o), 32'(FLEN - 1));
        tick(1);
        chk("f3_hop", 32'(wb_start_move_o), 32'd1);
        chk("f3_fcount", 32'(frame_count_o), 32'd3);
        tick(1);
        chk("f3_idle", 32'({busy_o, wb_start_move_o}), 32'd0);
        tick(3);
        chk("f3_stay_idle", 32'({busy_o, wb_start_move_o, wb_rd_en_o, m_valid_o}), 32'd0);

        // frame 4: reset at index 200
        enable_i = 1'b1;
        wait_idx(0);
        wait_idx(200);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 32'({m_data_o, m_index_o, m_valid_o, m_last_o,
                                   wb_rd_en_o, wb_start_move_o, busy_o}), 32'd0);
        chk("midrst_fcount", 32'(frame_count_o), 32'd0);
        exp_src = int'(src);
        exp_idx = 0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_busy", 32'(busy_o), 32'd1);
        tick(1);
        chk("post_rst_idx0", 32'({m_valid_o, m_index_o}), 32'({1'b1, 10'd0}));
        chk("post_rst_fcount", 32'(frame_count_o), 32'd0);

        // counter wrap from 0xFFFF
        wait_idx(10);
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        tick(1);
        chk("wrap_preload", 32'(frame_count_o), 32'hFFFF);
        wait_last();
        tick(1);
        chk("wrap_hop", 32'(wb_start_move_o), 32'd1);
        chk("wrap_fcount", 32'(frame_count_o), 32'd0);
        wait_idx(0);
        chk("wrap_next_frame", 32'({busy_o, frame_count_o}), 32'({1'b1, 16'd0}));
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
